// File: rtl/video_adapter_pkg.sv
// Shared types and helpers for the board video output adapter.
package video_adapter_pkg;

    typedef enum logic [1:0] {
        TRUNC    = 2'd0,
        SPATIAL  = 2'd1,
        TEMPORAL = 2'd2
    } dither_mode_t;

    // 2x2 ordered-dither matrix, indexed by {yph, xph}.
    localparam logic [1:0] BAYER2 [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

    // Scales a 2-bit Bayer entry to the LSB span being discarded (d = dropped bits).
    function automatic int unsigned bayer_threshold(input logic [1:0] b, input int d);
        if (d >= 2) return 32'(b) << (d - 2);
        else        return 32'(b) >> (2 - d);
    endfunction

endpackage

// File: rtl/video_dither_channel.sv
// One colour channel: add threshold, saturate, keep the top OUT_BITS, blank outside active video.
module video_dither_channel
    import video_adapter_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_ce,
    input  logic [IN_BITS-1:0]  pix,
    input  logic [IN_BITS-1:0]  thr,
    input  logic                de,
    output logic [OUT_BITS-1:0] out
);

    logic [IN_BITS:0] sum;

    // NOTE: state is written with <= only, so stage2 reads the sum stage1 held before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
            out <= '0;
        end else if (pix_ce) begin
            sum <= {1'b0, pix} + {1'b0, thr};
            if (!de)
                out <= '0;
            else if (sum[IN_BITS])
                out <= '1;
            else
                out <= sum[IN_BITS-1 -: OUT_BITS];
        end
    end

endmodule

// File: rtl/video_output_adapter.sv
// Board video output stage: colour depth reduction with optional ordered dither,
// two-stage pixel pipeline with syncs kept aligned and runtime sync polarity.
module video_output_adapter
    import video_adapter_pkg::*;
#(
    parameter int IN_BITS     = 8,
    parameter int OUT_BITS    = 6,
    parameter int DITHER_MODE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_ce,
    input  logic [IN_BITS-1:0]  in_r,
    input  logic [IN_BITS-1:0]  in_g,
    input  logic [IN_BITS-1:0]  in_b,
    input  logic                in_hs,
    input  logic                in_vs,
    input  logic                in_de,
    input  logic                invert_hs,
    input  logic                invert_vs,
    output logic [OUT_BITS-1:0] out_r,
    output logic [OUT_BITS-1:0] out_g,
    output logic [OUT_BITS-1:0] out_b,
    output logic                out_hs,
    output logic                out_vs,
    output logic                out_de
);

    localparam int           D    = IN_BITS - OUT_BITS;
    localparam dither_mode_t MODE = dither_mode_t'(DITHER_MODE);

    if (OUT_BITS > IN_BITS || OUT_BITS < 1) begin : g_bad_width
        $error("video_output_adapter: OUT_BITS must be in 1..IN_BITS");
    end
    if (DITHER_MODE < 0 || DITHER_MODE > 2) begin : g_bad_mode
        $error("video_output_adapter: DITHER_MODE must be 0, 1 or 2");
    end

    logic               hs_prev, vs_prev;
    logic               hs_rise, vs_rise;
    logic               xph, yph;
    logic [1:0]         frame;
    logic               hs_d1, vs_d1, de_d1;
    logic [1:0]         idx;
    logic [IN_BITS-1:0] thr;

    assign hs_rise = in_hs & ~hs_prev;
    assign vs_rise = in_vs & ~vs_prev;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        idx = {yph, xph};
        if (MODE == TEMPORAL)
            idx = idx ^ frame;
        thr = '0;
        if (MODE != TRUNC)
            thr = IN_BITS'(bayer_threshold(BAYER2[idx], D));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            xph     <= 1'b0;
            yph     <= 1'b0;
            frame   <= '0;
            hs_d1   <= 1'b0;
            vs_d1   <= 1'b0;
            de_d1   <= 1'b0;
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
            out_de  <= 1'b0;
        end else if (pix_ce) begin
            hs_prev <= in_hs;
            vs_prev <= in_vs;

            if (hs_rise)    xph <= 1'b0;
            else if (in_de) xph <= ~xph;

            // vsync wins when both syncs rise on the same pixel.
            if (vs_rise)      yph <= 1'b0;
            else if (hs_rise) yph <= ~yph;

            if (vs_rise) frame <= frame + 2'd1;

            hs_d1  <= in_hs;
            vs_d1  <= in_vs;
            de_d1  <= in_de;
            out_hs <= hs_d1 ^ invert_hs;
            out_vs <= vs_d1 ^ invert_vs;
            out_de <= de_d1;
        end
    end

    video_dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_ch_r (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .pix(in_r), .thr(thr), .de(de_d1), .out(out_r)
    );
    video_dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_ch_g (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .pix(in_g), .thr(thr), .de(de_d1), .out(out_g)
    );
    video_dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_ch_b (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .pix(in_b), .thr(thr), .de(de_d1), .out(out_b)
    );

endmodule

// File: tb/tb_video_output_adapter.sv
// Randomized bench for video_output_adapter: four instances (truncate, spatial, temporal,
// 8->8 pass-through) share one stimulus stream and are compared with an arithmetic model.
module tb_video_output_adapter;

    localparam int NI = 4;
    localparam int MODE_A [NI] = '{0, 1, 2, 2};
    localparam int OUTB_A [NI] = '{6, 6, 6, 8};
    localparam int BAYER  [4]  = '{0, 2, 3, 1};

    typedef struct {
        int r, g, b;
        bit hs, vs, de;
        int xpar, ypar, fr;
    } sample_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pix_ce = 1'b0;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic       in_hs = 1'b0, in_vs = 1'b0, in_de = 1'b0;
    logic       invert_hs = 1'b0, invert_vs = 1'b0;

    logic [5:0] o0_r, o0_g, o0_b, o1_r, o1_g, o1_b, o2_r, o2_g, o2_b;
    logic [7:0] o3_r, o3_g, o3_b;
    logic       o0_hs, o0_vs, o0_de, o1_hs, o1_vs, o1_de;
    logic       o2_hs, o2_vs, o2_de, o3_hs, o3_vs, o3_de;

    logic [31:0] act_rgb [NI];
    logic [31:0] act_sync[NI];
    logic [31:0] exp_rgb [NI];
    logic [31:0] exp_sync[NI];

    int n_checks = 0;
    int n_errors = 0;

    int      xcnt, ycnt, fcnt;
    bit      hs_prev, vs_prev;
    sample_t q[$];

    always #5 clk = ~clk;

    video_output_adapter #(.IN_BITS(8), .OUT_BITS(6), .DITHER_MODE(0)) u_m0 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .invert_hs(invert_hs), .invert_vs(invert_vs),
        .out_r(o0_r), .out_g(o0_g), .out_b(o0_b), .out_hs(o0_hs), .out_vs(o0_vs), .out_de(o0_de));
    video_output_adapter #(.IN_BITS(8), .OUT_BITS(6), .DITHER_MODE(1)) u_m1 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .invert_hs(invert_hs), .invert_vs(invert_vs),
        .out_r(o1_r), .out_g(o1_g), .out_b(o1_b), .out_hs(o1_hs), .out_vs(o1_vs), .out_de(o1_de));
    video_output_adapter #(.IN_BITS(8), .OUT_BITS(6), .DITHER_MODE(2)) u_m2 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .invert_hs(invert_hs), .invert_vs(invert_vs),
        .out_r(o2_r), .out_g(o2_g), .out_b(o2_b), .out_hs(o2_hs), .out_vs(o2_vs), .out_de(o2_de));
    video_output_adapter #(.IN_BITS(8), .OUT_BITS(8), .DITHER_MODE(2)) u_pt (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .invert_hs(invert_hs), .invert_vs(invert_vs),
        .out_r(o3_r), .out_g(o3_g), .out_b(o3_b), .out_hs(o3_hs), .out_vs(o3_vs), .out_de(o3_de));

    always_comb begin
        act_rgb[0]  = 32'({o0_r, o0_g, o0_b});
        act_rgb[1]  = 32'({o1_r, o1_g, o1_b});
        act_rgb[2]  = 32'({o2_r, o2_g, o2_b});
        act_rgb[3]  = 32'({o3_r, o3_g, o3_b});
        act_sync[0] = 32'({o0_hs, o0_vs, o0_de});
        act_sync[1] = 32'({o1_hs, o1_vs, o1_de});
        act_sync[2] = 32'({o2_hs, o2_vs, o2_de});
        act_sync[3] = 32'({o3_hs, o3_vs, o3_de});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected DAC code for one channel: (colour + scaled Bayer threshold) / 2^D, clamped.
    function automatic int chan(input int c, input int mode, input int ob, input sample_t s);
        int d, idx, t, v, maxv;
        d = 8 - ob;
        if (!s.de) return 0;
        idx = s.ypar * 2 + s.xpar;
        if (mode == 2) idx = idx ^ s.fr;
        if (mode == 0)   t = 0;
        else if (d >= 2) t = BAYER[idx] * (1 << (d - 2));
        else             t = BAYER[idx] / (1 << (2 - d));
        v    = (c + t) / (1 << d);
        maxv = (1 << ob) - 1;
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic sample_t zero_sample();
        sample_t s;
        s = '{r: 0, g: 0, b: 0, hs: 1'b0, vs: 1'b0, de: 1'b0, xpar: 0, ypar: 0, fr: 0};
        return s;
    endfunction

    task automatic model_reset();
        xcnt = 0; ycnt = 0; fcnt = 0;
        hs_prev = 1'b0; vs_prev = 1'b0;
        q.delete();
        q.push_back(zero_sample());
        for (int i = 0; i < NI; i++) begin
            exp_rgb[i]  = '0;
            exp_sync[i] = '0;
        end
    endtask

    // Called after each enabled edge: record the sample, then the output shows the previous one.
    task automatic model_advance();
        sample_t s, old;
        bit hr, vr;
        int ob;
        s = '{r: int'(in_r), g: int'(in_g), b: int'(in_b), hs: in_hs, vs: in_vs, de: in_de,
              xpar: xcnt % 2, ypar: ycnt % 2, fr: fcnt % 4};
        hr = in_hs && !hs_prev;
        vr = in_vs && !vs_prev;
        if (hr)         xcnt = 0;
        else if (in_de) xcnt++;
        if (vr)         ycnt = 0;
        else if (hr)    ycnt++;
        if (vr)         fcnt++;
        hs_prev = in_hs;
        vs_prev = in_vs;
        q.push_back(s);
        old = q.pop_front();
        for (int i = 0; i < NI; i++) begin
            ob = OUTB_A[i];
            exp_rgb[i] = 32'((chan(old.r, MODE_A[i], ob, old) << (2 * ob)) |
                             (chan(old.g, MODE_A[i], ob, old) << ob) |
                              chan(old.b, MODE_A[i], ob, old));
            exp_sync[i] = 32'({old.hs ^ invert_hs, old.vs ^ invert_vs, old.de});
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rgb[%0d]", i), act_rgb[i], exp_rgb[i]);
            check($sformatf("sync[%0d]", i), act_sync[i], exp_sync[i]);
        end
    endtask

    task automatic step(input bit ce);
        pix_ce = ce;
        @(posedge clk);
        #1;
        if (ce) model_advance();
        compare_all();
    endtask

    task automatic do_reset(input bit ce);
        reset  = 1'b1;
        pix_ce = ce;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all();
    endtask

    task automatic set_sync(input bit de, input bit hs, input bit vs);
        in_de = de;
        in_hs = hs;
        in_vs = vs;
    endtask

    localparam int T3_EXP [4] = '{16, 17, 17, 16};

    initial begin
        set_sync(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b1);

        // Spatial dither on two lines, plus saturation, truncation and pass-through.
        in_r = 8'h41; in_g = 8'hFF; in_b = 8'h43;
        set_sync(1'b1, 1'b0, 1'b0); step(1'b1);
        set_sync(1'b1, 1'b0, 1'b0); step(1'b1);
        check("t1_l1p0_r", o1_r, 16);
        check("t2_sat_g", o1_g, 63);
        check("t3_trunc_b", o0_b, 16);
        check("t6_pass_r", o3_r, 8'h41);
        set_sync(1'b0, 1'b1, 1'b0); step(1'b1);
        check("t1_l1p1_r", o1_r, 16);
        check("t2_sat_g2", o2_g, 63);
        set_sync(1'b0, 1'b0, 1'b0); step(1'b1);
        set_sync(1'b1, 1'b0, 1'b0); step(1'b1);
        set_sync(1'b1, 1'b0, 1'b0); step(1'b1);
        check("t1_l2p0_r", o1_r, 17);
        set_sync(1'b0, 1'b0, 1'b0); step(1'b1);
        check("t1_l2p1_r", o1_r, 16);
        check("t2_sat_g3", o1_g, 63);

        // Temporal mode at (0,0) over four frames; hs and vs rise together between frames.
        in_b = 8'h42;
        for (int f = 0; f < 4; f++) begin
            if (f == 0) begin
                do_reset(1'b0);
            end else begin
                set_sync(1'b0, 1'b1, 1'b1); step(1'b1);
                set_sync(1'b0, 1'b0, 1'b0); step(1'b1);
            end
            set_sync(1'b1, 1'b0, 1'b0); step(1'b1);
            set_sync(1'b0, 1'b0, 1'b0); step(1'b1);
            check($sformatf("t3_frame%0d_b", f), o2_b, T3_EXP[f]);
            check($sformatf("t3_trunc%0d_b", f), o0_b, 16);
        end

        // Blanking of full-scale colour and an inverted hsync pulse.
        in_r = 8'hFF; invert_hs = 1'b1;
        set_sync(1'b0, 1'b0, 1'b0); step(1'b1);
        check("t4_idle_hs", o1_hs, 1);
        set_sync(1'b0, 1'b1, 1'b0); step(1'b1);
        check("t4_blank_r", o1_r, 0);
        set_sync(1'b0, 1'b0, 1'b0); step(1'b1);
        check("t4_pulse_hs", o1_hs, 0);
        step(1'b1);
        check("t4_after_hs", o1_hs, 1);
        invert_hs = 1'b0;

        // Randomized traffic: first pix_ce every 3rd clk, then random enables and resets.
        for (int n = 0; n < 4000; n++) begin
            bit ce;
            int sel;
            if (n < 1500) ce = (n % 3 == 0);
            else          ce = ($urandom_range(0, 3) != 0);
            sel  = $urandom_range(0, 3);
            in_r = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom);
            in_g = 8'($urandom);
            in_b = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            set_sync($urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) invert_hs = ~invert_hs;
            if ($urandom_range(0, 99) == 0) invert_vs = ~invert_vs;
            if ($urandom_range(0, 299) == 0) do_reset(ce);
            else                            step(ce);
        end

        // Reset mid-line: the first pixel afterwards uses index 0 in every mode.
        invert_hs = 1'b0; invert_vs = 1'b0;
        in_r = 8'h42;
        set_sync(1'b1, 1'b0, 1'b0); step(1'b1);
        step(1'b1);
        do_reset(1'b0);
        check("t6_reset_r", o2_r, 0);
        step(1'b1);
        set_sync(1'b0, 1'b0, 1'b0); step(1'b1);
        check("t6_first_r", o2_r, 16);
        check("t6_first_r_sp", o1_r, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
